// File: rtl/q_row_fetch_if.sv
// ----------------------------------------------------------------------------
// q_row_fetch_if
//   Bundles the signals of q_row_fetch that are not clock or reset. These are
//   the start request, the RAM read port, and the parallel row output that
//   feeds the max-Q comparator.
//
//   modport slave  : the fetcher's view (q_row_fetch uses this one)
//   modport master : the view of the surrounding logic. It drives the
//                    request and the RAM read data, and consumes the row.
//
//   Signals
//     start        request a row fetch
//     state_idx    board state to fetch
//     occ_mask     bit k-1 set = cell k occupied
//     mem_rd_en    RAM read strobe
//     mem_addr     {state_idx, cell[3:0]}
//     mem_rd_data  RAM data, valid one cycle after mem_rd_en
//     busy         fetch in progress
//     valid        q_out_* hold a complete row
//     no_move      every cell of the held row is occupied
//     q_out_1..9   Q value per cell
// ----------------------------------------------------------------------------
interface q_row_fetch_if #(
    parameter int Q_W     = 8,
    parameter int STATE_W = 15
);
    logic                 start;
    logic [STATE_W-1:0]   state_idx;
    logic [8:0]           occ_mask;
    logic                 mem_rd_en;
    logic [STATE_W+3:0]   mem_addr;
    logic [Q_W-1:0]       mem_rd_data;
    logic                 busy;
    logic                 valid;
    logic                 no_move;
    logic [Q_W-1:0]       q_out_1;
    logic [Q_W-1:0]       q_out_2;
    logic [Q_W-1:0]       q_out_3;
    logic [Q_W-1:0]       q_out_4;
    logic [Q_W-1:0]       q_out_5;
    logic [Q_W-1:0]       q_out_6;
    logic [Q_W-1:0]       q_out_7;
    logic [Q_W-1:0]       q_out_8;
    logic [Q_W-1:0]       q_out_9;

    modport slave (
        input  start, state_idx, occ_mask, mem_rd_data,
        output mem_rd_en, mem_addr, busy, valid, no_move,
        output q_out_1, q_out_2, q_out_3, q_out_4, q_out_5,
        output q_out_6, q_out_7, q_out_8, q_out_9
    );

    modport master (
        output start, state_idx, occ_mask, mem_rd_data,
        input  mem_rd_en, mem_addr, busy, valid, no_move,
        input  q_out_1, q_out_2, q_out_3, q_out_4, q_out_5,
        input  q_out_6, q_out_7, q_out_8, q_out_9
    );
endinterface

// File: rtl/q_row_fetch.sv
// ----------------------------------------------------------------------------
// q_row_fetch
//   Upstream feeder for the 9-input max-Q comparator of the tic-tac-toe
//   Q-learning agent. A start request loads one board state's Q-table row.
//   The row is read from a synchronous single-port RAM, one cell per cycle.
//   Occupied cells are forced to MASK_VAL and never read. The nine values are
//   then presented in parallel with a valid flag.
//
//   Ports
//     clk    in  rising-edge clock
//     rst    in  synchronous, active-high reset
//     fetch  slave side of q_row_fetch_if. It carries the request, the RAM
//            read port and the row outputs.
//
//   Timing
//     Start is accepted at edge E0. Cell k is addressed during the cycle
//     after E(k). The RAM returns its data after E(k+1), and that data is
//     captured at E(k+2). valid rises at E10 whatever the mask is, so the
//     latency seen by the comparator is fixed.
// ----------------------------------------------------------------------------
module q_row_fetch #(
    parameter int             Q_W      = 8,
    parameter int             STATE_W  = 15,
    parameter logic [Q_W-1:0] MASK_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    q_row_fetch_if.slave fetch
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CELL = 4'd8;

    // Control and latched request
    state_t               state_q;
    logic [STATE_W-1:0]   idx_q;
    logic [8:0]           occ_q;
    logic [3:0]           cell_q;       // cell currently presented on mem_addr

    // RAM port registers
    logic                 rd_en_q;
    logic [STATE_W+3:0]   addr_q;

    // Describes the cell whose RAM data is on mem_rd_data this cycle
    logic                 pend_vld_q;
    logic [3:0]           pend_cell_q;
    logic                 pend_occ_q;

    // Registered outputs
    logic                 busy_q;
    logic                 valid_q;
    logic                 no_move_q;
    logic [Q_W-1:0]       row_q [9];

    // Next-cell and capture-value helpers
    logic [3:0]           cell_d;
    logic [Q_W-1:0]       cap_d;

    // NOTE: combinational blocks assign every output on every path, so no latch can be inferred.
    always_comb begin
        cell_d = cell_q + 4'd1;
        cap_d  = fetch.mem_rd_data;
        if (pend_occ_q) begin
            cap_d = MASK_VAL;
        end
    end

    // The FSM and all output registers live in this one block.
    // NOTE: sequential state uses non-blocking assignment only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            occ_q       <= '0;
            cell_q      <= '0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            pend_vld_q  <= 1'b0;
            pend_cell_q <= '0;
            pend_occ_q  <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            no_move_q   <= 1'b0;
            // NOTE: the row registers are reset on purpose. They are outputs that must read zero after reset, not RAM storage.
            for (int i = 0; i < 9; i++) begin
                row_q[i] <= '0;
            end
        end else begin
            pend_vld_q <= 1'b0;

            // Capture the cell whose data (or mask) belongs to this cycle.
            if (pend_vld_q) begin
                row_q[pend_cell_q] <= cap_d;
            end

            unique case (state_q)
                IDLE: begin
                    if (fetch.start) begin
                        idx_q     <= fetch.state_idx;
                        occ_q     <= fetch.occ_mask;
                        cell_q    <= 4'd0;
                        addr_q    <= {fetch.state_idx, 4'd0};
                        rd_en_q   <= ~fetch.occ_mask[0];
                        busy_q    <= 1'b1;
                        valid_q   <= 1'b0;
                        no_move_q <= 1'b0;
                        state_q   <= ISSUE;
                    end
                end

                ISSUE: begin
                    // The cell on mem_addr this cycle is read by the RAM at
                    // this edge, so its data is due one edge later.
                    pend_vld_q  <= 1'b1;
                    pend_cell_q <= cell_q;
                    pend_occ_q  <= occ_q[cell_q];
                    if (cell_q == LAST_CELL) begin
                        // mem_addr keeps pointing at cell 8.
                        rd_en_q <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        cell_q  <= cell_d;
                        addr_q  <= {idx_q, cell_d};
                        rd_en_q <= ~occ_q[cell_d];
                    end
                end

                DRAIN: begin
                    // Cell 8 is captured by the shared capture path above.
                    busy_q    <= 1'b0;
                    valid_q   <= 1'b1;
                    no_move_q <= &occ_q;
                    state_q   <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fetch.mem_rd_en = rd_en_q;
    assign fetch.mem_addr  = addr_q;
    assign fetch.busy      = busy_q;
    assign fetch.valid     = valid_q;
    assign fetch.no_move   = no_move_q;
    assign fetch.q_out_1   = row_q[0];
    assign fetch.q_out_2   = row_q[1];
    assign fetch.q_out_3   = row_q[2];
    assign fetch.q_out_4   = row_q[3];
    assign fetch.q_out_5   = row_q[4];
    assign fetch.q_out_6   = row_q[5];
    assign fetch.q_out_7   = row_q[6];
    assign fetch.q_out_8   = row_q[7];
    assign fetch.q_out_9   = row_q[8];

endmodule

// File: tb/tb_q_row_fetch.sv
// ----------------------------------------------------------------------------
// tb_q_row_fetch
//   Directed bench for q_row_fetch. It models a 1-cycle-latency RAM preloaded
//   with Q[s][k] = (s*9+k) mod 256. Inputs are driven and outputs sampled 1 ns
//   after each rising edge.
// ----------------------------------------------------------------------------
module tb_q_row_fetch;

    localparam int Q_W     = 8;
    localparam int STATE_W = 15;

    logic clk;
    logic rst;

    q_row_fetch_if #(.Q_W(Q_W), .STATE_W(STATE_W)) bus ();

    q_row_fetch #(
        .Q_W      (Q_W),
        .STATE_W  (STATE_W),
        .MASK_VAL (8'd0)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .fetch (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model and read monitor ----------------
    logic [STATE_W-1:0] cur_idx;   // expected state of the current fetch
    logic [8:0]         cur_mask;  // expected mask of the current fetch
    int rd_total = 0;
    int rd_bad   = 0;

    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            int s;
            int k;
            s = int'(bus.mem_addr[STATE_W+3:4]);
            k = int'(bus.mem_addr[3:0]);
            bus.mem_rd_data <= 8'((s * 9 + k) % 256);
            rd_total <= rd_total + 1;
            if (k > 8 || bus.mem_addr[STATE_W+3:4] != cur_idx || cur_mask[k]) begin
                rd_bad <= rd_bad + 1;
            end
        end
    end

    logic [7:0] q_arr [9];
    always_comb begin
        q_arr[0] = bus.q_out_1;
        q_arr[1] = bus.q_out_2;
        q_arr[2] = bus.q_out_3;
        q_arr[3] = bus.q_out_4;
        q_arr[4] = bus.q_out_5;
        q_arr[5] = bus.q_out_6;
        q_arr[6] = bus.q_out_7;
        q_arr[7] = bus.q_out_8;
        q_arr[8] = bus.q_out_9;
    end

    // ---------------- checking ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_row(input string tag, input logic [7:0] exp [9]);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("%s.q_out_%0d", tag, i + 1), 32'(q_arr[i]), 32'(exp[i]));
        end
    endtask

    // Accept a start at the next edge (E0), then count edges until valid.
    task automatic run_fetch(input string tag, input logic [STATE_W-1:0] idx,
                             input logic [8:0] mask, output int lat);
        cur_idx       = idx;
        cur_mask      = mask;
        bus.start     = 1'b1;
        bus.state_idx = idx;
        bus.occ_mask  = mask;
        step();
        bus.start = 1'b0;
        check({tag, ".busy@E0"}, 32'(bus.busy), 32'd1);
        lat = 0;
        while (!bus.valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    // ---------------- stimulus ----------------
    int lat;
    int rd0;
    logic [7:0] exp_row [9];

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.state_idx   = '0;
        bus.occ_mask    = '0;
        bus.mem_rd_data = '0;
        cur_idx         = '0;
        cur_mask        = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst.busy",    32'(bus.busy),      32'd0);
        check("rst.valid",   32'(bus.valid),     32'd0);
        check("rst.no_move", 32'(bus.no_move),   32'd0);
        check("rst.rd_en",   32'(bus.mem_rd_en), 32'd0);
        check("rst.addr",    32'(bus.mem_addr),  32'd0);

        // 1. Reset mid-fetch after 4 reads, then a clean fetch
        rd0           = rd_total;
        cur_idx       = 15'd5;
        cur_mask      = 9'd0;
        bus.start     = 1'b1;
        bus.state_idx = 15'd5;
        bus.occ_mask  = 9'd0;
        step();
        bus.start = 1'b0;
        repeat (4) step();
        check("t1.reads_before_rst", 32'(rd_total - rd0), 32'd4);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("t1.busy", 32'(bus.busy),  32'd0);
        check("t1.valid", 32'(bus.valid), 32'd0);
        exp_row = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        check_row("t1.cleared", exp_row);
        step();
        step();
        check("t1.valid_stays_low", 32'(bus.valid), 32'd0);
        run_fetch("t1b", 15'd3, 9'd0, lat);
        check("t1b.latency", 32'(lat), 32'd10);
        exp_row = '{8'd27, 8'd28, 8'd29, 8'd30, 8'd31, 8'd32, 8'd33, 8'd34, 8'd35};
        check_row("t1b", exp_row);

        // 2. state 0, nothing occupied
        rd0 = rd_total;
        run_fetch("t2", 15'd0, 9'd0, lat);
        check("t2.latency", 32'(lat),             32'd10);
        check("t2.reads",   32'(rd_total - rd0),  32'd9);
        check("t2.busy",    32'(bus.busy),        32'd0);
        check("t2.no_move", 32'(bus.no_move),     32'd0);
        check("t2.addr_hold", 32'(bus.mem_addr),  32'd8);
        exp_row = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        check_row("t2", exp_row);
        step();
        check("t2.valid_hold", 32'(bus.valid), 32'd1);

        // 3. state 100, cells 0,4,8 occupied (row base 900 mod 256 = 132)
        rd0       = rd_total;
        cur_idx   = 15'd100;
        cur_mask  = 9'b100010001;
        bus.start     = 1'b1;
        bus.state_idx = 15'd100;
        bus.occ_mask  = 9'b100010001;
        step();
        bus.start = 1'b0;
        check("t3.addr@E0",  32'(bus.mem_addr),  32'd1600);
        check("t3.rd_en@E0", 32'(bus.mem_rd_en), 32'd0);
        check("t3.valid@E0", 32'(bus.valid),     32'd0);
        lat = 0;
        while (!bus.valid && lat < 20) begin
            step();
            lat++;
        end
        check("t3.latency", 32'(lat),            32'd10);
        check("t3.reads",   32'(rd_total - rd0), 32'd6);
        check("t3.no_move", 32'(bus.no_move),    32'd0);
        exp_row = '{8'd0, 8'd133, 8'd134, 8'd135, 8'd0, 8'd137, 8'd138, 8'd139, 8'd0};
        check_row("t3", exp_row);

        // 4. all occupied
        rd0 = rd_total;
        run_fetch("t4", 15'd7, 9'h1FF, lat);
        check("t4.latency", 32'(lat),            32'd10);
        check("t4.reads",   32'(rd_total - rd0), 32'd0);
        check("t4.no_move", 32'(bus.no_move),    32'd1);
        exp_row = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        check_row("t4", exp_row);

        // 5. start pulsed 3 cycles into a fetch is ignored
        rd0           = rd_total;
        cur_idx       = 15'd4;
        cur_mask      = 9'd0;
        bus.start     = 1'b1;
        bus.state_idx = 15'd4;
        bus.occ_mask  = 9'd0;
        step();
        bus.start = 1'b0;
        lat = 0;
        repeat (3) begin
            step();
            lat++;
        end
        bus.start     = 1'b1;
        bus.state_idx = 15'd9;
        bus.occ_mask  = 9'h0F0;
        step();
        lat++;
        bus.start = 1'b0;
        while (!bus.valid && lat < 20) begin
            step();
            lat++;
        end
        check("t5.latency", 32'(lat),            32'd10);
        check("t5.reads",   32'(rd_total - rd0), 32'd9);
        exp_row = '{8'd36, 8'd37, 8'd38, 8'd39, 8'd40, 8'd41, 8'd42, 8'd43, 8'd44};
        check_row("t5", exp_row);
        repeat (3) step();
        check("t5.no_second_fetch", 32'(bus.busy), 32'd0);
        check("t5.reads_after",     32'(rd_total - rd0), 32'd9);

        // 6. back-to-back: start in the cycle valid=1
        run_fetch("t6a", 15'd1, 9'd0, lat);
        check("t6a.latency", 32'(lat), 32'd10);
        check("t6a.q_out_1", 32'(bus.q_out_1), 32'd9);
        cur_idx       = 15'd2;
        bus.start     = 1'b1;
        bus.state_idx = 15'd2;
        bus.occ_mask  = 9'd0;
        step();
        bus.start = 1'b0;
        check("t6.valid_drop", 32'(bus.valid), 32'd0);
        check("t6.busy",       32'(bus.busy),  32'd1);
        lat = 0;
        while (!bus.valid && lat < 20) begin
            step();
            lat++;
        end
        check("t6b.latency", 32'(lat), 32'd10);
        exp_row = '{8'd18, 8'd19, 8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25, 8'd26};
        check_row("t6b", exp_row);

        // Any read of an occupied cell, a cell above 8, or the wrong state
        check("bad_reads", 32'(rd_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
